square27_load_ctrl: RTL



---
 rtl/square27_load_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/square27_load_ctrl.sv
// -----------------------------------------------------------------------------
// square27_load_ctrl
//
// Sequencer for the 27-row squaring compressor and its serial-load shift
// register bank. One operand per transaction:
//   IDLE   : accept operand a on in_valid && in_ready
//   SHIFT  : WIDTH cycles, column t = 0..WIDTH-1, MSB first:
//            lane_bit[k] = a[k] & a[WIDTH-1-t], so row K ends up as a[K] ? a : 0
//   SETTLE : SETTLE cycles with lane_bit = 0; dst is captured on the last one
//   HOLD   : out_data presented with out_valid until out_ready
//
// Ports
//   clk        in   single clock, posedge
//   rst_n      in   synchronous active-low reset (aborts any transaction)
//   in_valid   in   operand offered
//   in_ready   out  operand accepted this cycle if in_valid (IDLE only)
//   in_data    in   [WIDTH]    operand a
//   lane_bit   out  [WIDTH]    serial data for shift-register row k (pin srcK_)
//   dst        in   [OUT_BITS] compressor outputs
//   out_valid  out  result held
//   out_ready  in   result consumer ready
//   out_data   out  [OUT_BITS] captured dst
//   busy       out  high in SHIFT, SETTLE and HOLD
//
// SETTLE must be in 1..15 (4-bit settle counter).
// -----------------------------------------------------------------------------

// Per-lane registered serial bit. Outside an enabled cycle the lane drives 0,
// which keeps the shift register fed with zeros in every non-SHIFT state.
module square27_lane_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_a,
   input  logic i_col,
   output logic o_bit
);

   logic r_bit;

   always_ff @(posedge clk) begin
      if (!rst_n)     r_bit <= 1'b0;
      else if (i_en)  r_bit <= i_a & i_col;
      else            r_bit <= 1'b0;
   end

   assign o_bit = r_bit;

endmodule

module square27_load_ctrl #(
   parameter int WIDTH    = 27,
   parameter int OUT_BITS = 32,
   parameter int SETTLE   = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_data,
   output logic [WIDTH-1:0]    lane_bit,
   input  logic [OUT_BITS-1:0] dst,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OUT_BITS-1:0] out_data,
   output logic                busy
);

   localparam int             T_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [T_W-1:0] T_LAST = T_W'(WIDTH - 1);
   localparam logic [T_W-1:0] T_PREV = T_W'(WIDTH - 2);
   localparam logic [3:0]     S_LAST = 4'(SETTLE - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [T_W-1:0]      r_t, w_t_nxt;
   logic [3:0]          r_settle, w_settle_nxt;
   logic [WIDTH-1:0]    r_a, w_a_nxt;
   logic [OUT_BITS-1:0] r_out_data, w_out_data_nxt;
   logic                r_in_ready, r_out_valid, r_busy;

   logic                w_in_fire, w_out_fire, w_t_last, w_s_last;
   logic                w_lane_en, w_col_bit;
   logic [WIDTH-1:0]    w_lane_a;
   logic [T_W-1:0]      w_col_idx;

   // r_in_ready is only set while in IDLE, so it qualifies the accept alone
   assign w_in_fire  = in_valid & r_in_ready;
   assign w_out_fire = out_ready & r_out_valid;
   assign w_t_last   = (r_t == T_LAST);
   assign w_s_last   = (r_settle == S_LAST);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_t         <= '0;
         r_settle    <= '0;
         r_a         <= '0;
         r_out_data  <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_t         <= w_t_nxt;
         r_settle    <= w_settle_nxt;
         r_a         <= w_a_nxt;
         r_out_data  <= w_out_data_nxt;
         // status flags are registered decodes of the next state
         r_in_ready  <= (w_state_nxt == ST_IDLE);
         r_out_valid <= (w_state_nxt == ST_HOLD);
         r_busy      <= (w_state_nxt != ST_IDLE);
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_in_fire)  w_state_nxt = ST_SHIFT;
         ST_SHIFT:  if (w_t_last)   w_state_nxt = ST_SETTLE;
         ST_SETTLE: if (w_s_last)   w_state_nxt = ST_HOLD;
         ST_HOLD:   if (w_out_fire) w_state_nxt = ST_IDLE;
         default:                   w_state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   // Lane bits are registered, so the value for column t is computed one cycle
   // early: column 0 at the accept edge, column t+1 during SHIFT cycle t.
   always_comb begin
      w_t_nxt        = r_t;
      w_settle_nxt   = r_settle;
      w_a_nxt        = r_a;
      w_out_data_nxt = r_out_data;
      w_lane_en      = 1'b0;
      w_lane_a       = r_a;
      // column index of the next SHIFT cycle; unused on the last column
      w_col_idx      = w_t_last ? '0 : (T_PREV - r_t);
      w_col_bit      = r_a[w_col_idx];
      case (r_state)
         ST_IDLE: begin
            if (w_in_fire) begin
               w_a_nxt   = in_data;
               w_t_nxt   = '0;
               w_lane_en = 1'b1;
               w_lane_a  = in_data;
               w_col_bit = in_data[WIDTH-1];
            end
         end
         ST_SHIFT: begin
            if (!w_t_last) begin
               w_t_nxt   = r_t + T_W'(1);
               w_lane_en = 1'b1;
            end else begin
               w_settle_nxt = '0;
            end
         end
         ST_SETTLE: begin
            // capture edge is the SETTLE-th edge after the last shift edge
            if (w_s_last) w_out_data_nxt = dst;
            else          w_settle_nxt   = r_settle + 4'd1;
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------- lane array
   for (genvar k = 0; k < WIDTH; k++) begin : g_lane
      square27_lane_cell u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .i_en  (w_lane_en),
         .i_a   (w_lane_a[k]),
         .i_col (w_col_bit),
         .o_bit (lane_bit[k])
      );
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = r_busy;

endmodule
